// File: rtl/aes128_decryptor.sv
// rtl/aes128_decryptor.sv - iterative AES-128 block decryptor, one round per clock; optional AES128_DEC_KEY_CACHE_EN key cache
module aes128_decryptor (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher
);

    typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

    // Byte 0 of each table sits in bits [2047:2040].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2040 - 8*int'(x) +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[2040 - 8*int'(x) +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (row r, column c) lives at byte index 4c+r; InvShiftRows rotates row r right by r.
    function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [0:3];
        logic [7:0]   m9 [0:3];
        logic [7:0]   mb [0:3];
        logic [7:0]   md [0:3];
        logic [7:0]   me [0:3];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8*(4*c + r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
        return o;
    endfunction

    fsm_t         fsm, fsm_next;
    logic [3:0]   rnd;
    logic [127:0] rk [0:10];
    logic [127:0] data_in;
    logic [127:0] st;
    logic         accept, hit, kx_step, dec_step;
    logic         cache_hit;
    logic [3:0]   kidx;
    logic [127:0] rk_prev, rk_new, round_out;
    logic [31:0]  tmp, n0, n1, n2, n3;

`ifdef AES128_DEC_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_valid;

    assign cache_hit = cache_valid && (key == cache_key);

    // Remember the last fully expanded key; an unfinished expansion never validates the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key   <= '0;
            cache_valid <= 1'b0;
        end else if (kx_step && rnd == 4'd10) begin
            cache_key   <= rk[0];
            cache_valid <= 1'b1;
        end else if (accept && !hit) begin
            cache_valid <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Next round key from the previous one: RotWord, SubWord, Rcon, then the word chain.
    always_comb begin
        kidx    = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
        rk_prev = rk[kidx];
        tmp     = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]), sbox(rk_prev[31:24])}
                  ^ {rcon(rnd), 24'h0};
        n0      = rk_prev[127:96] ^ tmp;
        n1      = rk_prev[95:64] ^ n0;
        n2      = rk_prev[63:32] ^ n1;
        n3      = rk_prev[31:0] ^ n2;
        rk_new  = {n0, n1, n2, n3};
        round_out = inv_sr_sb(st);
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_next;
    end

    // Next-state decode and per-state datapath enables.
    always_comb begin
        fsm_next = fsm;
        accept   = 1'b0;
        hit      = 1'b0;
        kx_step  = 1'b0;
        dec_step = 1'b0;
        case (fsm)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (cache_hit) begin
                        hit      = 1'b1;
                        fsm_next = DEC;
                    end else begin
                        fsm_next = KEXP;
                    end
                end
            end
            KEXP: begin
                kx_step = 1'b1;
                if (rnd == 4'd10) fsm_next = DEC;
            end
            DEC: begin
                dec_step = 1'b1;
                if (rnd == 4'd0) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Key schedule, round state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd     <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
            data_in <= '0;
            st      <= '0;
            cipher  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (fsm_next != IDLE);
            if (accept) begin
                data_in <= in;
                if (hit) begin
                    st  <= in ^ rk[10];
                    rnd <= 4'd9;
                end else begin
                    rk[0] <= key;
                    rnd   <= 4'd1;
                end
            end
            if (kx_step) begin
                rk[rnd] <= rk_new;
                if (rnd == 4'd10) begin
                    st  <= data_in ^ rk_new;
                    rnd <= 4'd9;
                end else begin
                    rnd <= rnd + 4'd1;
                end
            end
            if (dec_step) begin
                if (rnd == 4'd0) begin
                    cipher <= round_out ^ rk[0];
                    done   <= 1'b1;
                end else begin
                    st  <= inv_mix_columns(round_out ^ rk[rnd]);
                    rnd <= rnd - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes128_decryptor.sv
// tb/tb_aes128_decryptor.sv - self-checking bench for aes128_decryptor
module tb_aes128_decryptor;

`ifdef AES128_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] V1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] in_d = '0;
    logic [127:0] key_d = '0;
    logic         busy, done;
    logic [127:0] cipher;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] sb [$];
    logic [127:0] last_plain = '0;
    bit           mvalid = 1'b0;
    logic [127:0] mkey = '0;
    int           lat_a, lat_b;

    aes128_decryptor dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_d),
        .key    (key_d),
        .busy   (busy),
        .done   (done),
        .cipher (cipher)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at a negedge: drives a start request and records expectations.
    task automatic start_op(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                            output int lat);
        in_d  = ct;
        key_d = k;
        start = 1'b1;
        sb.push_back(pt);
        lat    = (CACHE && mvalid && mkey == k) ? 10 : 20;
        mvalid = 1'b1;
        mkey   = k;
    endtask

    // Counts edges from the one sampling start until done; returns at the done-cycle negedge.
    task automatic wait_done(input string tag, input int exp_lat, input int perturb_at);
        int   lat;
        bit   seen, busy_ok, hold_ok;
        logic [127:0] exp;
        lat = -1; seen = 0; busy_ok = 1; hold_ok = 1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (cipher !== last_plain) hold_ok = 0;
                if (lat == perturb_at) begin
                    start = 1'b1;
                    in_d  = ~in_d;
                    key_d = ~key_d;
                end
            end
        end
        check({tag, " done_seen"}, 128'(seen), 128'(1));
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " busy_during"}, 128'(busy_ok), 128'(1));
        check({tag, " cipher_held"}, 128'(hold_ok), 128'(1));
        if (seen) begin
            exp = sb.pop_front();
            check({tag, " cipher"}, cipher, exp);
            check({tag, " busy_at_done"}, 128'(busy), 128'(0));
            last_plain = exp;
        end
    endtask

    initial begin
        bit no_done;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset cipher", cipher, 128'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle holds", 128'(busy), 128'(0));

        // Vector 1, then done must be a single-cycle pulse
        start_op(V1_CT, V1_KEY, V1_PT, lat_a);
        wait_done("v1", lat_a, -1);
        @(negedge clk);
        check("v1 done_width", 128'(done), 128'(0));

        // Vector 2; vector 1 result must be held while it runs
        start_op(V2_CT, V2_KEY, V2_PT, lat_a);
        wait_done("v2", lat_a, -1);
        @(negedge clk);

        // Re-pulsed start and changing in/key mid-operation are ignored
        start_op(V1_CT, V1_KEY, V1_PT, lat_a);
        wait_done("ignore", lat_a, 3);
        @(negedge clk);

        // Reset at E12 aborts with no done
        start_op(V2_CT, V2_KEY, V2_PT, lat_a);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 128'(busy), 128'(0));
        check("abort cipher", cipher, 128'(0));
        void'(sb.pop_front());
        last_plain = '0;
        mvalid = 1'b0;
        no_done = 1;
        repeat (30) begin
            @(negedge clk);
            if (done) no_done = 0;
        end
        check("abort no_done", 128'(no_done), 128'(1));

        // Operation after reset; back-to-back start in its done cycle
        start_op(V1_CT, V1_KEY, V1_PT, lat_a);
        wait_done("post_rst", lat_a, -1);
        start_op(V2_CT, V2_KEY, V2_PT, lat_b);
        wait_done("b2b", lat_b, -1);
        @(negedge clk);

        // Key reuse sequence (short latency only when the key cache is built in)
        start_op(V1_CT, V1_KEY, V1_PT, lat_a);
        wait_done("kc_a", lat_a, -1);
        @(negedge clk);
        start_op(V2_CT, V2_KEY, V2_PT, lat_a);
        wait_done("kc_b", lat_a, -1);
        @(negedge clk);
        start_op(V2_CT, V2_KEY, V2_PT, lat_a);
        wait_done("kc_c", lat_a, -1);
        @(negedge clk);
        start_op(V1_CT, V1_KEY, V1_PT, lat_a);
        wait_done("kc_d", lat_a, -1);
        @(negedge clk);

        check("scoreboard empty", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
